// File: rtl/conv_pkg.sv
// Shared constants, helpers and FSM encoding for the conv MAC unit.
package conv_pkg;

    localparam int unsigned Q_DATA_WIDTH = 16;
    localparam int unsigned Q_FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_FINAL,
        ST_OUT
    } conv_state_e;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Largest value of a w-bit two's complement number.
    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value of a w-bit two's complement number.
    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/conv_unit_mac_array_mac_lane_adder.sv
// LANES signed multipliers feeding a combinational adder tree; one
// ACC_WIDTH partial sum for the current step per cycle.
module mac_lane_adder
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Q_DATA_WIDTH,
    parameter int unsigned N          = 25,
    parameter int unsigned LANES      = 5,
    parameter int unsigned STEP_WIDTH = 3,
    parameter int unsigned ACC_WIDTH  = 38
) (
    input  logic [N*DATA_WIDTH-1:0]       image_i,
    input  logic [N*DATA_WIDTH-1:0]       filter_i,
    input  logic [STEP_WIDTH-1:0]         step_i,
    output logic signed [ACC_WIDTH-1:0]   psum_o
);

    localparam int unsigned IW = (clog2(N) > 0) ? clog2(N) : 1;

    logic signed [DATA_WIDTH-1:0] img_a [N];
    logic signed [DATA_WIDTH-1:0] flt_a [N];

    function automatic logic signed [2*DATA_WIDTH-1:0] smul(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [2*DATA_WIDTH-1:0] ax;
        logic signed [2*DATA_WIDTH-1:0] bx;
        ax = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        bx = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    // Unpack the flat vectors; element 0 sits in the MSBs.
    always_comb begin
        for (int unsigned e = 0; e < N; e++) begin
            img_a[e] = image_i[(N-1-e)*DATA_WIDTH +: DATA_WIDTH];
            flt_a[e] = filter_i[(N-1-e)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Sum this step's lane products; lanes past the last element add zero.
    always_comb begin
        logic signed [2*DATA_WIDTH-1:0] prod;
        int unsigned idx;
        psum_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            idx  = int'(step_i) * LANES + k;
            prod = '0;
            if (idx < N) begin
                prod = smul(img_a[IW'(idx)], flt_a[IW'(idx)]);
            end
            psum_o = psum_o + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        end
    end

endmodule

// File: rtl/conv_unit_mac_array.sv
// Single-output-pixel convolution MAC: LANES products per cycle, bias,
// optional ReLU and saturation, valid/ready on both sides.
module conv_unit_mac_array
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Q_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = Q_FRAC_BITS,
    parameter int unsigned D          = 1,
    parameter int unsigned F          = 5,
    parameter int unsigned LANES      = 5,
    localparam int unsigned N         = D * F * F,
    localparam int unsigned STEPS     = (N + LANES - 1) / LANES,
    localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + clog2(N) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] image,
    input  logic [N*DATA_WIDTH-1:0] filter,
    input  logic [DATA_WIDTH-1:0]   bias,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    busy
);

    localparam int unsigned SW = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

    conv_state_e                  state_q;
    logic [N*DATA_WIDTH-1:0]      image_q;
    logic [N*DATA_WIDTH-1:0]      filter_q;
    logic [DATA_WIDTH-1:0]        bias_q;
    logic                         relu_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [SW-1:0]                step_q;
    logic [DATA_WIDTH-1:0]        result_q;
    logic [DATA_WIDTH-1:0]        result_d;
    logic                         out_valid_q;
    logic                         in_ready_q;
    logic                         busy_q;
    logic signed [ACC_WIDTH-1:0]  psum;

    mac_lane_adder #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .LANES      (LANES),
        .STEP_WIDTH (SW),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_lanes (
        .image_i  (image_q),
        .filter_i (filter_q),
        .step_i   (step_q),
        .psum_o   (psum)
    );

    // Add bias in Q format, drop fraction bits (floor), ReLU, then saturate.
    always_comb begin
        logic signed [ACC_WIDTH-1:0] bias_ext;
        logic signed [ACC_WIDTH-1:0] sum;
        logic signed [ACC_WIDTH-1:0] v;
        bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
        sum      = acc_q + (bias_ext <<< FRAC_BITS);
        v        = sum >>> FRAC_BITS;
        if (relu_q && v[ACC_WIDTH-1]) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            result_d = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            result_d = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result_d = v[DATA_WIDTH-1:0];
        end
    end

    // Job sequencing, accumulation and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            image_q     <= '0;
            filter_q    <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        image_q    <= image;
                        filter_q   <= filter;
                        bias_q     <= bias;
                        relu_q     <= relu_en;
                        acc_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + psum;
                    if (step_q == SW'(STEPS - 1)) begin
                        state_q <= ST_FINAL;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                ST_FINAL: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_unit_mac_array.sv
// Directed bench for conv_unit_mac_array: one instance with LANES=5
// (STEPS=5) and one with LANES=4 (STEPS=7) sharing the operand buses.
module tb_conv_unit_mac_array;

    localparam int DW = 16;
    localparam int NE = 25;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid5 = 1'b0;
    logic            in_valid4 = 1'b0;
    logic            out_ready = 1'b0;
    logic [NE*DW-1:0] image = '0;
    logic [NE*DW-1:0] filter = '0;
    logic [DW-1:0]   bias = '0;
    logic            relu_en = 1'b0;

    logic            in_ready5, out_valid5, busy5;
    logic [DW-1:0]   result5;
    logic            in_ready4, out_valid4, busy4;
    logic [DW-1:0]   result4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_unit_mac_array #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .D          (1),
        .F          (5),
        .LANES      (5)
    ) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .image     (image),
        .filter    (filter),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid5),
        .out_ready (out_ready),
        .result    (result5),
        .busy      (busy5)
    );

    conv_unit_mac_array #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .D          (1),
        .F          (5),
        .LANES      (4)
    ) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .image     (image),
        .filter    (filter),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .result    (result4),
        .busy      (busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 4) ? in_ready4 : in_ready5;
    endfunction

    function automatic logic ov(input int sel);
        return (sel == 4) ? out_valid4 : out_valid5;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 4) ? busy4 : busy5;
    endfunction

    function automatic logic [DW-1:0] res(input int sel);
        return (sel == 4) ? result4 : result5;
    endfunction

    task automatic fill(input logic [DW-1:0] iv, input logic [DW-1:0] fv);
        for (int e = 0; e < NE; e++) begin
            image[(NE-1-e)*DW +: DW]  = iv;
            filter[(NE-1-e)*DW +: DW] = fv;
        end
    endtask

    task automatic fill_ramp(input logic [DW-1:0] iv, input int stepv);
        for (int e = 0; e < NE; e++) begin
            image[(NE-1-e)*DW +: DW]  = iv;
            filter[(NE-1-e)*DW +: DW] = DW'(e * stepv);
        end
    endtask

    task automatic start(input int sel, input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(rdy(sel)), 32'd1);
        if (sel == 4) in_valid4 = 1'b1; else in_valid5 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_valid5 = 1'b0;
    endtask

    task automatic wait_out(input int sel, input int exp_lat, input string tag);
        int lat = 0;
        while (!ov(sel) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_out(input int sel, input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(ov(sel)), 32'd0);
        check({tag, "_ready_back"}, 32'(rdy(sel)), 32'd1);
    endtask

    task automatic job(input int sel, input logic [DW-1:0] exp, input int exp_lat, input string tag);
        start(sel, tag);
        wait_out(sel, exp_lat, tag);
        check({tag, "_result"}, 32'(res(sel)), 32'(exp));
        finish_out(sel, tag);
    endtask

    initial begin
        // Reset values while reset is held.
        #3;
        check("rst_ov5", 32'(out_valid5), 32'd0);
        check("rst_busy5", 32'(busy5), 32'd0);
        check("rst_res5", 32'(result5), 32'd0);
        check("rst_ov4", 32'(out_valid4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdy5", 32'(in_ready5), 32'd1);
        check("rst_rdy4", 32'(in_ready4), 32'd1);

        // Basic: 25 * 1.0 * 1.0 = 25.0
        fill(16'h0100, 16'h0100);
        bias = 16'h0000;
        relu_en = 1'b0;
        job(5, 16'h1900, 6, "basic");

        // Partial last step, large sum saturates.
        fill_ramp(16'h0100, 16'h0100);
        bias = 16'h0080;
        job(4, 16'h7FFF, 8, "ramp_sat");

        // Partial last step, in range: 18.75 + 0.5
        fill_ramp(16'h0100, 16'h0010);
        job(4, 16'h1340, 8, "ramp");

        // Negative result and ReLU.
        fill(16'h0100, 16'hFF00);
        bias = 16'h0000;
        relu_en = 1'b0;
        job(5, 16'hE700, 6, "neg");
        relu_en = 1'b1;
        job(5, 16'h0000, 6, "relu");
        relu_en = 1'b0;

        // Saturation both directions.
        fill(16'h7F00, 16'h7F00);
        job(5, 16'h7FFF, 6, "satpos");
        fill(16'h7F00, 16'h8100);
        job(5, 16'h8000, 6, "satneg");

        // Backpressure with an ignored second request.
        fill(16'h0100, 16'h0100);
        start(5, "bp");
        wait_out(5, 6, "bp");
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                @(negedge clk);
                fill(16'h0200, 16'h0300);
                in_valid5 = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid5 = 1'b0;
            check("bp_result", 32'(result5), 32'h1900);
            check("bp_ov", 32'(out_valid5), 32'd1);
            check("bp_rdy", 32'(in_ready5), 32'd0);
        end
        finish_out(5, "bp");
        @(posedge clk);
        #1;
        check("bp_idle", 32'(busy5), 32'd0);

        // Reset during MAC, then a clean job.
        fill(16'h7F00, 16'h7F00);
        start(4, "abort");
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_ov", 32'(out_valid4), 32'd0);
        check("abort_busy", 32'(busy4), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        fill(16'h0100, 16'h0100);
        bias = 16'h0000;
        job(4, 16'h1900, 8, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_unit_mac_array.md
Name: conv_unit_mac_array

Overview:
- Parametrised successor to the single-PE sequential convolution unit.
- Computes one output pixel: dot product of a D*F*F image window and filter in signed fixed point.
- Uses LANES parallel multipliers, an optional bias, optional ReLU and output saturation.
- Sits between the window/line-buffer stage and the conv-layer output collector; valid/ready on both sides replaces fixed-cycle waiting.

Parameters:
- DATA_WIDTH, 16, width of every image/filter/bias/result element, signed two's complement.
- FRAC_BITS, 8, fractional bits of the Q format (Q7.8 at default).
- D, 1, filter channel count.
- F, 5, filter edge size.
- LANES, 5, multipliers evaluated per cycle; 1 <= LANES <= D*F*F.
- Localparams (not overridable):
  - N = D*F*F.
  - STEPS = ceil(N/LANES).
  - ACC_WIDTH = 2*DATA_WIDTH + clog2(N) + 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  window/filter/bias/cfg valid.
- in_ready  out  1  unit can accept a new job.
- image  in  N*DATA_WIDTH  window, element 0 in MSBs (bit 0 side of [0:..] vector).
- filter  in  N*DATA_WIDTH  filter, same packing.
- bias  in  DATA_WIDTH  Q-format bias added once.
- relu_en  in  1  apply ReLU to the final value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_WIDTH  saturated Q-format result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; accumulator, step counter, captured operands and result all clear to 0.
  - out_valid=0, busy=0, in_ready=1 once reset deasserts.
  - Reset mid-job aborts the job; no partial result is ever presented.
- FSM states: IDLE, MAC, FINAL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register image, filter, bias and relu_en; clear acc; step=0; go to MAC.
- MAC (exactly STEPS cycles, in_ready=0):
  - Each cycle, acc += sum over lanes k of image[step*LANES+k]*filter[step*LANES+k].
  - Each product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH.
  - Lanes whose index is >= N contribute 0 (last partial step).
  - step increments; after step==STEPS-1, go to FINAL.
- FINAL (1 cycle):
  - Compute v = (acc + (bias sign-extended, shifted left FRAC_BITS)) arithmetically shifted right FRAC_BITS (truncate toward -inf).
  - If relu_en and v<0, v=0.
  - Saturate v to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], register into result, assert out_valid, go to OUT.
- OUT:
  - result and out_valid are held stable until out_ready=1.
  - On out_valid&out_ready, out_valid drops the next cycle and the state goes to IDLE.
  - in_ready is not asserted in the same cycle as the output handshake; no overlap of jobs.
- Latency: input handshake at cycle 0 gives out_valid at cycle STEPS+1. Throughput is one result per STEPS+3 cycles with out_ready held high.
- in_valid while busy is ignored; the inputs are not sampled.
- No internal overflow: ACC_WIDTH covers N worst-case products plus bias.

Decomposition:
- Shared package conv_pkg holds the clog2 function, the Q-format constants (DATA_WIDTH, FRAC_BITS defaults), the saturation min/max constants and the FSM state encoding.
- Natural sub-module: mac_lane_adder.
  - LANES signed multipliers plus a combinational adder tree.
  - Output is one ACC_WIDTH partial sum per cycle.
- FSM, accumulator, rounding/ReLU/saturation stay in the top module.

Test Plan:
- Basic: D=1,F=5,LANES=5; all image=0x0100 (1.0), all filter=0x0100, bias=0, relu_en=0 -> result=0x1900 (25.0); out_valid exactly 6 cycles after the input handshake.
- Partial lanes: LANES=4 (STEPS=7); image[i]=0x0100, filter[i]=i*0x0100 for i=0..24, bias=0x0080 (0.5) -> result=0x12C80 saturated to 0x7FFF. Repeat with filter[i]=i*0x0010 (i/16): sum=18.75, plus 0.5 -> 0x1340; latency 8 cycles.
- Sign/ReLU: all image=0x0100, filter=0xFF00 (-1.0), bias=0 -> relu_en=0 gives 0xE700 (-25.0); relu_en=1 gives 0x0000.
- Saturation: all image=0x7F00, filter=0x7F00 -> 0x7FFF; filter=0x8100 -> 0x8000 with relu_en=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, second in_valid ignored; raise out_ready -> one handshake, in_ready=1 next cycle.
- Reset mid-MAC: assert reset at step 2 -> out_valid=0 and busy=0 immediately (asynchronous); a subsequent job returns the correct result with no residue from the aborted accumulator.
